// File: rtl/ticket_dispense_arbiter.sv
// ticket_dispense_arbiter
// Shares one ticket dispenser motor and one change-return chute between
// N_REQ ticket-machine front ends. It grants the mechanism round-robin,
// drives it for a fixed number of cycles and then pulses ack to the owner.
//
// Ports
//   clk       : clock, rising edge
//   clear     : asynchronous active-high reset
//   disp_req  : per-requester dispense request (level, held until ack)
//   rtn_req   : per-requester return request (level, held until ack)
//   grant     : one-hot owner of the mechanism, 0 when idle
//   grant_id  : binary index of the owner, 0 when idle
//   motor_on  : dispenser motor drive
//   coin_out  : change-return chute drive
//   ack       : one-cycle completion pulse to the owner
//   busy      : high whenever a service is in progress (not IDLE)
module ticket_dispense_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DISP_CYCLES = 8,
    parameter int unsigned RTN_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [N_REQ-1:0] disp_req,
    input  logic [N_REQ-1:0] rtn_req,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_id,
    output logic             motor_on,
    output logic             coin_out,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned MAX_K = (DISP_CYCLES > RTN_CYCLES) ? DISP_CYCLES : RTN_CYCLES;
    localparam int unsigned CNT_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_RETURN   = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         owner_q, owner_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic               motor_on_q, motor_on_d;
    logic               coin_out_q, coin_out_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;

    logic [N_REQ-1:0]   pending;
    logic               found;
    logic [2:0]         winner;

    assign pending = disp_req | rtn_req;

    // Round-robin search: first pending index starting at ptr, wrapping mod N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && pending[IDX_W'((32'(ptr_q) + k) % N_REQ)]) begin
                found  = 1'b1;
                winner = 3'((32'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // Next-state logic; outputs are decoded from the next state so they leave flops.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d = winner;
                    // Dispense wins over return for the same requester.
                    if (disp_req[IDX_W'(winner)]) begin
                        state_d = ST_DISPENSE;
                        cnt_d   = CNT_W'(DISP_CYCLES - 1);
                    end else begin
                        state_d = ST_RETURN;
                        cnt_d   = CNT_W'(RTN_CYCLES - 1);
                    end
                end
            end
            ST_DISPENSE, ST_RETURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        grant_d    = busy_d ? (N_REQ'(1) << owner_d) : '0;
        grant_id_d = busy_d ? owner_d : 3'd0;
        motor_on_d = (state_d == ST_DISPENSE);
        coin_out_d = (state_d == ST_RETURN);
        ack_d      = (state_d == ST_DONE) ? (N_REQ'(1) << owner_d) : '0;
    end

    // State and output registers; clear aborts any service without an ack.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            motor_on_q <= 1'b0;
            coin_out_q <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            motor_on_q <= motor_on_d;
            coin_out_q <= coin_out_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign motor_on = motor_on_q;
    assign coin_out = coin_out_q;
    assign ack      = ack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ticket_dispense_arbiter.sv
// Testbench for ticket_dispense_arbiter: directed scenarios plus random
// request traffic compared cycle by cycle against a service-schedule model.
module tb_ticket_dispense_arbiter;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned DISP_CYCLES = 8;
    localparam int unsigned RTN_CYCLES  = 4;

    logic             clk = 1'b0;
    logic             clear;
    logic [N_REQ-1:0] disp_req;
    logic [N_REQ-1:0] rtn_req;
    logic [N_REQ-1:0] grant;
    logic [2:0]       grant_id;
    logic             motor_on;
    logic             coin_out;
    logic [N_REQ-1:0] ack;
    logic             busy;

    ticket_dispense_arbiter #(
        .N_REQ       (N_REQ),
        .DISP_CYCLES (DISP_CYCLES),
        .RTN_CYCLES  (RTN_CYCLES)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .disp_req (disp_req),
        .rtn_req  (rtn_req),
        .grant    (grant),
        .grant_id (grant_id),
        .motor_on (motor_on),
        .coin_out (coin_out),
        .ack      (ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Expected outputs for one cycle.
    typedef struct {
        logic [N_REQ-1:0] grant;
        logic [2:0]       gid;
        logic             motor;
        logic             coin;
        logic [N_REQ-1:0] ack;
        logic             busy;
        logic             kind;   // 1 = return service
    } exp_t;

    exp_t        cur;
    exp_t        sched[$];
    int unsigned ptr;
    int          checks = 0;
    int          errors = 0;
    bit          rand_en;
    int          log_q[$];       // completed services: id*2 + is_return
    logic        prev_coin;

    function automatic exp_t idle_entry();
        exp_t e;
        e.grant = '0; e.gid = '0; e.motor = 1'b0; e.coin = 1'b0;
        e.ack = '0; e.busy = 1'b0; e.kind = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        ptr = 0;
        cur = idle_entry();
    endtask

    // On each clock edge: when idle, pick a winner and lay out its whole
    // service (K drive cycles then one ack cycle) as a schedule of cycles.
    task automatic model_step();
        exp_t        e;
        int          w;
        int unsigned k_len;
        if (clear) begin
            model_reset();
            return;
        end
        if (!cur.busy) begin
            w = -1;
            for (int k = 0; k < int'(N_REQ); k++) begin
                int i;
                i = (int'(ptr) + k) % int'(N_REQ);
                if (w < 0 && (disp_req[i] || rtn_req[i])) w = i;
            end
            if (w >= 0) begin
                e       = idle_entry();
                e.busy  = 1'b1;
                e.grant = N_REQ'(1) << w;
                e.gid   = 3'(w);
                e.kind  = !disp_req[w];
                e.motor = !e.kind;
                e.coin  = e.kind;
                k_len   = e.kind ? RTN_CYCLES : DISP_CYCLES;
                repeat (k_len) sched.push_back(e);
                e.motor = 1'b0;
                e.coin  = 1'b0;
                e.ack   = e.grant;
                sched.push_back(e);
                ptr = (w + 1) % N_REQ;
            end
        end
        if (sched.size() > 0) cur = sched.pop_front();
        else                  cur = idle_entry();
    endtask

    // One clock: advance model, apply requester behaviour, check at negedge.
    task automatic tick();
        logic [N_REQ-1:0] drop;
        logic             drop_rtn;
        @(posedge clk);
        drop     = cur.ack;
        drop_rtn = cur.kind;
        model_step();
        #1;
        if (drop_rtn) rtn_req  = rtn_req  & ~drop;
        else          disp_req = disp_req & ~drop;
        if (rand_en) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!disp_req[i] && !rtn_req[i] && $urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       disp_req[i] = 1'b1;
                        1:       rtn_req[i]  = 1'b1;
                        default: begin disp_req[i] = 1'b1; rtn_req[i] = 1'b1; end
                    endcase
                end
            end
        end
        @(negedge clk);
        check("grant",    32'(grant),    32'(cur.grant));
        check("grant_id", 32'(grant_id), 32'(cur.gid));
        check("motor_on", 32'(motor_on), 32'(cur.motor));
        check("coin_out", 32'(coin_out), 32'(cur.coin));
        check("ack",      32'(ack),      32'(cur.ack));
        check("busy",     32'(busy),     32'(cur.busy));
        check("grant_onehot", 32'($onehot0(grant)), 32'(1));
        check("drive_mutex",  32'(motor_on & coin_out), 32'(0));
        if (ack != '0) log_q.push_back(int'(grant_id) * 2 + int'(prev_coin));
        prev_coin = coin_out;
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((disp_req != '0 || rtn_req != '0 || busy || cur.busy) && n < budget) begin
            tick();
            n++;
        end
        check("quiet_timeout", 32'(n < budget), 32'(1));
    endtask

    // Single request from idle; checks latency window explicitly.
    task automatic single_service(input int idx, input bit is_rtn, input int drop_at);
        int k_len;
        k_len = is_rtn ? int'(RTN_CYCLES) : int'(DISP_CYCLES);
        if (is_rtn) rtn_req[idx] = 1'b1;
        else        disp_req[idx] = 1'b1;
        for (int c = 1; c <= k_len + 2; c++) begin
            tick();
            if (c == drop_at) begin
                if (is_rtn) rtn_req[idx] = 1'b0;
                else        disp_req[idx] = 1'b0;
            end
            check("svc_drive", 32'(is_rtn ? coin_out : motor_on), 32'(c <= k_len));
            check("svc_other", 32'(is_rtn ? motor_on : coin_out), 32'(0));
            check("svc_ack",   32'(ack), (c == k_len + 1) ? (32'(1) << idx) : 32'(0));
            check("svc_busy",  32'(busy), 32'(c <= k_len + 1));
            if (c <= k_len + 1) check("svc_gid", 32'(grant_id), 32'(idx));
        end
    endtask

    task automatic check_log(input string tag, input int base, input int exp_q[$]);
        check({tag, "_count"}, 32'(log_q.size() - base), 32'(exp_q.size()));
        if (log_q.size() - base == exp_q.size()) begin
            foreach (exp_q[j]) check(tag, 32'(log_q[base + j]), 32'(exp_q[j]));
        end
    endtask

    initial begin
        int base;
        clear     = 1'b1;
        disp_req  = '0;
        rtn_req   = '0;
        rand_en   = 1'b0;
        prev_coin = 1'b0;
        model_reset();
        repeat (2) tick();
        check("rst_grant",    32'(grant),    32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_motor",    32'(motor_on), 32'(0));
        check("rst_coin",     32'(coin_out), 32'(0));
        check("rst_ack",      32'(ack),      32'(0));
        check("rst_busy",     32'(busy),     32'(0));
        clear = 1'b0;

        // All four dispense, twice: order 0,1,2,3 both rounds (pointer wraps).
        base = log_q.size();
        disp_req = '1;
        wait_quiet(200);
        disp_req = '1;
        wait_quiet(200);
        check_log("rr_order", base, '{0, 2, 4, 6, 0, 2, 4, 6});

        // Single dispense on 0, single return on 2.
        single_service(0, 1'b0, 0);
        single_service(2, 1'b1, 0);

        // Requester 1 wants both, requester 2 dispense: 1 disp, 2 disp, 1 rtn.
        base = log_q.size();
        disp_req[1] = 1'b1;
        rtn_req[1]  = 1'b1;
        disp_req[2] = 1'b1;
        wait_quiet(200);
        check_log("dual_order", base, '{2, 4, 3});

        // Requester 3 drops its request in cycle 3; service still completes.
        single_service(3, 1'b0, 3);

        // Clear mid-dispense: pointer is 3, so 3 wins first; after clear 1 wins.
        single_service(2, 1'b0, 0);
        base = log_q.size();
        disp_req = 4'b1010;
        repeat (4) tick();
        check("pre_clr_motor", 32'(motor_on), 32'(1));
        check("pre_clr_gid",   32'(grant_id), 32'(3));
        #2;
        clear = 1'b1;
        model_reset();
        #1;
        check("clr_motor", 32'(motor_on), 32'(0));
        check("clr_grant", 32'(grant),    32'(0));
        check("clr_busy",  32'(busy),     32'(0));
        check("clr_ack",   32'(ack),      32'(0));
        tick();
        clear = 1'b0;
        wait_quiet(200);
        check_log("clr_order", base, '{2, 6});

        // Random traffic against the model.
        rand_en = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        wait_quiet(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
